branch_resolve_unit: RTL

Sequential branch/jump resolver for the multicycle core; it consumes the comparison flags produced by `branch_cond_gen` and owns the architectural PC register. The control FSM hands it one control-transfer (or sequential) instruction per request over a valid/ready handshake. The block evaluates the condition, computes and checks the target, commits the next PC, and reports link value, misalignment and branch statistics.

---
 rtl/riscv_defs_pkg.sv | 38 +++
 rtl/branch_cond_gen.sv | 14 +
 rtl/branch_resolve_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V control-transfer definitions: opcodes, branch funct3 codes,
// resolver FSM states and the branch decision helper.
package riscv_defs;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_COMMIT = 2'd2
    } brs_state_e;

    // Reserved encodings 010/011 resolve as not taken.
    function automatic logic br_decide(input logic [2:0] f3, input logic eq,
                                       input logic lt, input logic ltu);
        logic t;
        case (f3)
            F3_BEQ:  t = eq;
            F3_BNE:  t = !eq;
            F3_BLT:  t = lt;
            F3_BGE:  t = !lt;
            F3_BLTU: t = ltu;
            F3_BGEU: t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cond_gen.sv
// Comparison flags for conditional branches: equal, signed and unsigned less-than.
module branch_cond_gen (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        br_eq,
    output logic        br_lt,
    output logic        br_ltu
);

    assign br_eq  = (rs1 == rs2);
    assign br_lt  = ($signed(rs1) < $signed(rs2));
    assign br_ltu = (rs1 < rs2);

endmodule

// File: rtl/branch_resolve_unit.sv
// Three-state branch/jump resolver owning the architectural PC and branch
// statistics counters.
module branch_resolve_unit
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resolve_valid,
    output logic             resolve_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [31:0]      imm_b,
    input  logic [31:0]      imm_j,
    input  logic [31:0]      imm_i,
    output logic [31:0]      pc,
    output logic             done,
    output logic             taken,
    output logic [31:0]      link,
    output logic             misalign,
    output logic             illegal,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    brs_state_e       state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]      imm_b_q, imm_b_d, imm_j_q, imm_j_d, imm_i_q, imm_i_d;
    logic             eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      pc_q, pc_d, link_q, link_d;
    logic             done_q, done_d, taken_q, taken_d;
    logic             misalign_q, misalign_d, illegal_q, illegal_d;
    logic [CNT_W-1:0] br_count_q, br_count_d, taken_count_q, taken_count_d;

    logic             cmp_eq, cmp_lt, cmp_ltu;
    logic             is_br, is_jump, tk, mis;
    logic [31:0]      seq_pc;

    branch_cond_gen u_cond (
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .br_eq  (cmp_eq),
        .br_lt  (cmp_lt),
        .br_ltu (cmp_ltu)
    );

    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        funct3_d      = funct3_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        imm_b_d       = imm_b_q;
        imm_j_d       = imm_j_q;
        imm_i_d       = imm_i_q;
        eq_d          = eq_q;
        lt_d          = lt_q;
        ltu_d         = ltu_q;
        target_d      = target_q;
        pc_d          = pc_q;
        link_d        = link_q;
        taken_d       = taken_q;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        done_d        = 1'b0;
        misalign_d    = 1'b0;
        illegal_d     = 1'b0;

        seq_pc  = pc_q + 32'd4;
        is_br   = (opcode_q == OP_BRANCH);
        is_jump = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);
        tk      = is_br ? br_decide(funct3_q, eq_q, lt_q, ltu_q) : is_jump;
        mis     = tk && (target_q[1:0] != 2'b00);

        case (state_q)
            ST_IDLE: begin
                if (resolve_valid) begin
                    opcode_d = opcode;
                    funct3_d = funct3;
                    rs1_d    = rs1;
                    rs2_d    = rs2;
                    imm_b_d  = imm_b;
                    imm_j_d  = imm_j;
                    imm_i_d  = imm_i;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                eq_d  = cmp_eq;
                lt_d  = cmp_lt;
                ltu_d = cmp_ltu;
                // PC is stable here: it only moves in COMMIT.
                if (opcode_q == OP_BRANCH)    target_d = pc_q + imm_b_q;
                else if (opcode_q == OP_JAL)  target_d = pc_q + imm_j_q;
                else if (opcode_q == OP_JALR) target_d = (rs1_q + imm_i_q) & ~32'h1;
                else                          target_d = seq_pc;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                done_d     = 1'b1;
                taken_d    = tk;
                link_d     = seq_pc;
                misalign_d = mis;
                illegal_d  = is_br && (funct3_q[2:1] == 2'b01);
                // A misaligned taken target leaves the PC for the trap handler.
                pc_d       = !tk ? seq_pc : (mis ? pc_q : target_q);
                if (is_br) br_count_d = br_count_q + CNT_W'(1);
                if (is_br && tk) taken_count_d = taken_count_q + CNT_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            opcode_q      <= '0;
            funct3_q      <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            imm_b_q       <= '0;
            imm_j_q       <= '0;
            imm_i_q       <= '0;
            eq_q          <= 1'b0;
            lt_q          <= 1'b0;
            ltu_q         <= 1'b0;
            target_q      <= '0;
            pc_q          <= RESET_PC;
            link_q        <= '0;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            misalign_q    <= 1'b0;
            illegal_q     <= 1'b0;
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            funct3_q      <= funct3_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            imm_b_q       <= imm_b_d;
            imm_j_q       <= imm_j_d;
            imm_i_q       <= imm_i_d;
            eq_q          <= eq_d;
            lt_q          <= lt_d;
            ltu_q         <= ltu_d;
            target_q      <= target_d;
            pc_q          <= pc_d;
            link_q        <= link_d;
            done_q        <= done_d;
            taken_q       <= taken_d;
            misalign_q    <= misalign_d;
            illegal_q     <= illegal_d;
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign resolve_ready = (state_q == ST_IDLE);
    assign pc            = pc_q;
    assign done          = done_q;
    assign taken         = taken_q;
    assign link          = link_q;
    assign misalign      = misalign_q;
    assign illegal       = illegal_q;
    assign br_count      = br_count_q;
    assign taken_count   = taken_count_q;

endmodule
